// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-way
// instruction/data/loader memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam logic [3:0] FULL_MASK = 4'b1111;

    // Bit positions of each requester in eligibility/grant vectors
    localparam int G_IF = 0;
    localparam int G_DM = 1;
    localparam int G_LD = 2;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM,
        OWN_LD
    } owner_t;

    typedef enum logic [1:0] {
        K_READ,
        K_WRITE,
        K_ERR
    } kind_t;

    function automatic logic out_of_range(
        input logic [31:0] addr,
        input int          aw
    );
        return (addr >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// Fixed-priority (LD > DM > IF) winner select with a
// saturating wait counter that forces a starved IF through.
module arb_prio_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 3,
    parameter int WCW      = 2
) (
    input  logic [2:0]     i_elig,
    input  logic           i_if_req,
    input  logic [WCW-1:0] i_wait_cnt,
    output logic [2:0]     o_grant,
    output logic [WCW-1:0] o_wait_nxt
);

    logic w_force_if;

    assign w_force_if = i_elig[G_IF] &&
                        (i_wait_cnt == WCW'(MAX_WAIT));

    always_comb begin
        o_grant = 3'b000;
        if (w_force_if) begin
            o_grant[G_IF] = 1'b1;
        end else if (i_elig[G_LD]) begin
            o_grant[G_LD] = 1'b1;
        end else if (i_elig[G_DM]) begin
            o_grant[G_DM] = 1'b1;
        end else if (i_elig[G_IF]) begin
            o_grant[G_IF] = 1'b1;
        end
    end

    // Holds while IF waits on its own response
    always_comb begin
        o_wait_nxt = i_wait_cnt;
        if (!i_if_req || o_grant[G_IF]) begin
            o_wait_nxt = '0;
        end else if (i_elig[G_IF] &&
                     (i_wait_cnt != WCW'(MAX_WAIT))) begin
            o_wait_nxt = i_wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF, DM and loader onto one synchronous-read
// memory; responses come back one cycle after each grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [3:0]        dm_wr_mask,
    output logic [31:0]       dm_rdata,
    output logic              dm_valid,
    output logic              dm_err,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       ld_rdata,
    output logic              ld_valid,
    output logic              ld_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int WCW =
        (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    owner_t         r_owner;
    kind_t          r_kind;
    logic [WCW-1:0] r_wait_cnt;

    logic [2:0]     w_elig;
    logic [2:0]     w_grant;
    logic [WCW-1:0] w_wait_nxt;

    owner_t         w_win;
    kind_t          w_kind;
    logic           w_sel_we;
    logic           w_sel_oor;
    logic [31:0]    w_sel_addr;
    logic [31:0]    w_sel_wdata;
    logic [3:0]     w_sel_mask;
    logic           w_acc;
    logic           w_wr;

    assign w_elig[G_IF] = if_req && (r_owner != OWN_IF);
    assign w_elig[G_DM] = dm_req && (r_owner != OWN_DM);
    assign w_elig[G_LD] = ld_req && (r_owner != OWN_LD);

    arb_prio_sel #(
        .MAX_WAIT (MAX_WAIT),
        .WCW      (WCW)
    ) u_sel (
        .i_elig     (w_elig),
        .i_if_req   (if_req),
        .i_wait_cnt (r_wait_cnt),
        .o_grant    (w_grant),
        .o_wait_nxt (w_wait_nxt)
    );

    // IF only reads; the loader always writes whole words
    always_comb begin
        w_win       = OWN_NONE;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_mask  = '0;
        unique case (1'b1)
            w_grant[G_LD]: begin
                w_win       = OWN_LD;
                w_sel_we    = ld_we;
                w_sel_addr  = ld_addr;
                w_sel_wdata = ld_wdata;
                w_sel_mask  = FULL_MASK;
            end
            w_grant[G_DM]: begin
                w_win       = OWN_DM;
                w_sel_we    = dm_we;
                w_sel_addr  = dm_addr;
                w_sel_wdata = dm_wdata;
                w_sel_mask  = dm_wr_mask;
            end
            w_grant[G_IF]: begin
                w_win       = OWN_IF;
                w_sel_addr  = if_addr;
            end
            default: ;
        endcase
    end

    assign w_sel_oor = out_of_range(w_sel_addr, ADDR_W);

    assign w_kind = w_sel_oor ? K_ERR :
                    w_sel_we  ? K_WRITE : K_READ;

    assign w_acc = !rst_in && (w_win != OWN_NONE) &&
                   !w_sel_oor;
    assign w_wr  = w_acc && w_sel_we;

    assign mem_en    = w_acc;
    assign mem_we    = w_wr ? w_sel_mask : 4'b0000;
    assign mem_addr  = w_sel_addr[ADDR_W+1:2];
    assign mem_wdata = w_wr ? w_sel_wdata : 32'd0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_owner    <= OWN_NONE;
            r_kind     <= K_READ;
            r_wait_cnt <= '0;
        end else begin
            r_owner    <= w_win;
            r_kind     <= w_kind;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Reset kills a response that is already in flight
    assign if_valid = !rst_in && (r_owner == OWN_IF);
    assign dm_valid = !rst_in && (r_owner == OWN_DM);
    assign ld_valid = !rst_in && (r_owner == OWN_LD);

    assign if_err = if_valid && (r_kind == K_ERR);
    assign dm_err = dm_valid && (r_kind == K_ERR);
    assign ld_err = ld_valid && (r_kind == K_ERR);

    assign if_rdata = (if_valid && r_kind == K_READ) ?
                      mem_rdata : 32'd0;
    assign dm_rdata = (dm_valid && r_kind == K_READ) ?
                      mem_rdata : 32'd0;
    assign ld_rdata = (ld_valid && r_kind == K_READ) ?
                      mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus randomized traffic checked
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW = 6;
    localparam int MW = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wr_mask;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_err;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [31:0] ld_rdata;
    logic        ld_valid;
    logic        ld_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk_in = ~clk_in;

    mem_port_arbiter #(
        .ADDR_W   (AW),
        .MAX_WAIT (MW)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_err     (if_err),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_wr_mask (dm_wr_mask),
        .dm_rdata   (dm_rdata),
        .dm_valid   (dm_valid),
        .dm_err     (dm_err),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_rdata   (ld_rdata),
        .ld_valid   (ld_valid),
        .ld_err     (ld_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory macro with a backdoor preload path
    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_a;
    logic [31:0] pl_d;

    always @(posedge clk_in) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int i = 0; i < 4; i++)
                if (mem_we[i])
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        dmw;
        logic [31:0] dma;
        logic [31:0] dmd;
        logic [3:0]  dmm;
        logic        ldr;
        logic        ldw;
        logic [31:0] lda;
        logic [31:0] ldd;
        logic        en;
        logic [3:0]  we;
        logic [5:0]  ma;
        logic [31:0] wd;
        logic [2:0]  vld;
        logic [2:0]  err;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[$];
    int   n_pass;
    int   n_tot;
    int   cyc;

    function automatic vec_t mk(
        input logic [31:0] rst, ifr, ifa,
        input logic [31:0] dmr, dmw, dma, dmd, dmm,
        input logic [31:0] ldr, ldw, lda, ldd,
        input logic [31:0] en, we, ma, wd,
        input logic [31:0] vld, err, rd
    );
        vec_t v;
        v.rst = 1'(rst);  v.ifr = 1'(ifr);  v.ifa = ifa;
        v.dmr = 1'(dmr);  v.dmw = 1'(dmw);  v.dma = dma;
        v.dmd = dmd;      v.dmm = 4'(dmm);
        v.ldr = 1'(ldr);  v.ldw = 1'(ldw);  v.lda = lda;
        v.ldd = ldd;
        v.en  = 1'(en);   v.we  = 4'(we);   v.ma  = 6'(ma);
        v.wd  = wd;       v.vld = 3'(vld);  v.err = 3'(err);
        v.rd  = rd;
        return v;
    endfunction

    function automatic string nm(input string s);
        return $sformatf("cyc%0d %s", cyc, s);
    endfunction

    task automatic chk(input string s,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h",
                      nm(s), act, exp);
    endtask

    // Random-phase requester state: 0 = IF, 1 = DM, 2 = LD
    logic        rq  [3];
    logic        rwe [3];
    logic [31:0] ra  [3];
    logic [31:0] rwd [3];
    logic [3:0]  rmk [3];

    // Reference model state
    logic [31:0] ref_mem [64];
    int          m_owner;
    int          m_kind;
    int          m_wait;
    logic [31:0] m_rd;
    logic [2:0]  vprev;
    int          win;
    int          wrd;
    logic        oor;
    logic [2:0]  el;

    task automatic set_vec(input vec_t v);
        rst_in = v.rst;
        if_req = v.ifr;  if_addr = v.ifa;
        dm_req = v.dmr;  dm_we = v.dmw;  dm_addr = v.dma;
        dm_wdata = v.dmd;  dm_wr_mask = v.dmm;
        ld_req = v.ldr;  ld_we = v.ldw;  ld_addr = v.lda;
        ld_wdata = v.ldd;
    endtask

    task automatic check_vec(input vec_t v);
        chk("mem_en", 32'(mem_en), 32'(v.en));
        chk("mem_we", 32'(mem_we), 32'(v.we));
        if (v.en) chk("mem_addr", 32'(mem_addr), 32'(v.ma));
        if (v.we != 4'h0) chk("mem_wdata", mem_wdata, v.wd);
        chk("valid", 32'({ld_valid, dm_valid, if_valid}),
            32'(v.vld));
        chk("err", 32'({ld_err, dm_err, if_err}), 32'(v.err));
        chk("if_rdata", if_rdata, v.vld[0] ? v.rd : 32'd0);
        chk("dm_rdata", dm_rdata, v.vld[1] ? v.rd : 32'd0);
        chk("ld_rdata", ld_rdata, v.vld[2] ? v.rd : 32'd0);
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = 6'(a);
        pl_d  = d;
        @(posedge clk_in);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic new_req(input int p);
        rq[p]  = 1'b1;
        rwe[p] = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0)
            ra[p] = $urandom | 32'h100;
        else
            ra[p] = 32'($urandom_range(0, 255));
        rwd[p] = $urandom;
        rmk[p] = (p == 2) ? 4'hF : 4'($urandom_range(0, 15));
    endtask

    task automatic drive_rand();
        if_req = rq[0];  if_addr = ra[0];
        dm_req = rq[1];  dm_we = rwe[1];  dm_addr = ra[1];
        dm_wdata = rwd[1];  dm_wr_mask = rmk[1];
        ld_req = rq[2];  ld_we = rwe[2];  ld_addr = ra[2];
        ld_wdata = rwd[2];
    endtask

    task automatic model_eval();
        logic [3:0]  ewe;
        logic [2:0]  ev;
        logic [2:0]  ee;
        logic [31:0] erd;
        win = -1;
        for (int p = 0; p < 3; p++)
            el[p] = rq[p] && (m_owner != p);
        if (!rst_in) begin
            if (el[0] && m_wait == MW) win = 0;
            else
                for (int k = 2; k >= 0; k--)
                    if (win < 0 && el[k]) win = k;
        end
        oor = 1'b0;
        wrd = 0;
        ewe = 4'h0;
        if (win >= 0) begin
            oor = ra[win] >= 32'(1 << (AW + 2));
            wrd = int'((ra[win] >> 2) % 64);
            if (!oor && rwe[win]) ewe = rmk[win];
        end
        chk("mem_en", 32'(mem_en), 32'(win >= 0 && !oor));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        if (win >= 0 && !oor)
            chk("mem_addr", 32'(mem_addr), 32'(wrd));
        if (ewe != 4'h0)
            chk("mem_wdata", mem_wdata, rwd[win]);
        for (int p = 0; p < 3; p++) begin
            ev[p] = !rst_in && (m_owner == p);
            ee[p] = ev[p] && (m_kind == 2);
        end
        chk("valid", 32'({ld_valid, dm_valid, if_valid}),
            32'(ev));
        chk("err", 32'({ld_err, dm_err, if_err}), 32'(ee));
        erd = (m_kind == 0) ? m_rd : 32'd0;
        chk("if_rdata", if_rdata, ev[0] ? erd : 32'd0);
        chk("dm_rdata", dm_rdata, ev[1] ? erd : 32'd0);
        chk("ld_rdata", ld_rdata, ev[2] ? erd : 32'd0);
        vprev = ev;
    endtask

    task automatic model_commit();
        if (rst_in) begin
            m_owner = -1;
            m_wait  = 0;
        end else begin
            if (!rq[0] || win == 0) m_wait = 0;
            else if (el[0] && m_wait < MW) m_wait++;
            m_owner = win;
            if (win >= 0) begin
                m_kind = oor ? 2 : (rwe[win] ? 1 : 0);
                if (m_kind == 0) m_rd = ref_mem[wrd];
                if (m_kind == 1)
                    for (int b = 0; b < 4; b++)
                        if (rmk[win][b])
                            ref_mem[wrd][8*b +: 8] =
                                rwd[win][8*b +: 8];
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        cyc    = 0;
        pl_en  = 1'b0;
        pl_a   = '0;
        pl_d   = '0;
        set_vec(mk(1,0,0, 0,0,0,0,0, 0,0,0,0,
                   0,0,0,0, 0,0,0));

        // rst ifr ifa | dmr dmw dma dmd dmm | ldr ldw lda ldd
        // | en we ma wd | vld err rd
        tv.push_back(mk(1,1,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0,0,
                        1,0,0,0, 0,0,0));
        tv.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 1,0,32'h00258513));
        tv.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,1,4, 1,0,8,0,0, 0,0,0,0,
                        1,0,2,0, 0,0,0));
        tv.push_back(mk(0,1,4, 1,0,8,0,0, 0,0,0,0,
                        1,0,1,0, 2,0,32'h11223344));
        tv.push_back(mk(0,1,4, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 1,0,32'hCAFEF00D));
        tv.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,0,0, 1,1,8,32'hAABBCCDD,3, 0,0,0,0,
                        1,3,2,32'hAABBCCDD, 0,0,0));
        tv.push_back(mk(0,0,0, 1,1,8,32'hAABBCCDD,3, 0,0,0,0,
                        0,0,0,0, 2,0,0));
        tv.push_back(mk(0,0,0, 1,0,8,0,0, 0,0,0,0,
                        1,0,2,0, 0,0,0));
        tv.push_back(mk(0,0,0, 1,0,8,0,0, 0,0,0,0,
                        0,0,0,0, 2,0,32'h1122CCDD));
        tv.push_back(mk(0,0,0, 1,0,12,0,0,
                        1,1,12,32'h5A5A5A5A,
                        1,15,3,32'h5A5A5A5A, 0,0,0));
        tv.push_back(mk(0,0,0, 1,0,12,0,0,
                        1,1,12,32'h5A5A5A5A,
                        1,0,3,0, 4,0,0));
        tv.push_back(mk(0,0,0, 1,0,12,0,0, 0,0,0,0,
                        0,0,0,0, 2,0,32'h5A5A5A5A));
        tv.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,0,0, 1,1,0,32'hFFFFFFFF,0,
                        0,0,0,0, 1,0,0,0, 0,0,0));
        tv.push_back(mk(0,0,0, 1,1,0,32'hFFFFFFFF,0,
                        0,0,0,0, 0,0,0,0, 2,0,0));
        tv.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0,0,
                        1,0,0,0, 0,0,0));
        tv.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 1,0,32'h00258513));
        tv.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,0,0, 1,0,32'h100,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,0,0, 1,0,32'h100,0,0, 0,0,0,0,
                        0,0,0,0, 2,2,0));
        tv.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,0,0, 0,0,0,0,0,
                        1,1,32'h80000000,32'h12345678,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,0,0, 0,0,0,0,0,
                        1,1,32'h80000000,32'h12345678,
                        0,0,0,0, 4,4,0));
        tv.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,1,8, 1,0,4,0,0, 1,0,0,0,
                        1,0,0,0, 0,0,0));
        tv.push_back(mk(0,1,8, 1,0,4,0,0, 1,0,0,0,
                        1,0,1,0, 4,0,32'h00258513));
        tv.push_back(mk(0,1,8, 1,0,4,0,0, 1,0,4,0,
                        1,0,1,0, 2,0,32'hCAFEF00D));
        tv.push_back(mk(0,1,8, 1,0,12,0,0, 1,0,4,0,
                        1,0,2,0, 4,0,32'hCAFEF00D));
        tv.push_back(mk(0,1,8, 1,0,12,0,0, 1,0,0,0,
                        1,0,0,0, 1,0,32'h1122CCDD));
        tv.push_back(mk(0,0,0, 1,0,12,0,0, 1,0,0,0,
                        1,0,3,0, 4,0,32'h00258513));
        tv.push_back(mk(0,0,0, 1,0,12,0,0, 0,0,0,0,
                        0,0,0,0, 2,0,32'h5A5A5A5A));
        tv.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,1,4, 0,0,0,0,0, 0,0,0,0,
                        1,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,4, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));
        tv.push_back(mk(0,1,4, 0,0,0,0,0, 0,0,0,0,
                        1,0,1,0, 0,0,0));
        tv.push_back(mk(0,1,4, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 1,0,32'hCAFEF00D));
        tv.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,
                        0,0,0,0, 0,0,0));

        @(posedge clk_in);
        #1;
        preload(0, 32'h00258513);
        preload(1, 32'hCAFEF00D);
        preload(2, 32'h11223344);
        preload(3, 32'h00000000);

        for (int i = 0; i < tv.size(); i++) begin
            cyc = i;
            set_vec(tv[i]);
            @(negedge clk_in);
            check_vec(tv[i]);
            @(posedge clk_in);
            #1;
        end

        // Randomized phase: fresh memory image, model from reset
        set_vec(mk(1,0,0, 0,0,0,0,0, 0,0,0,0,
                   0,0,0,0, 0,0,0));
        for (int p = 0; p < 3; p++) begin
            rq[p] = 1'b0;  rwe[p] = 1'b0;  ra[p] = '0;
            rwd[p] = '0;   rmk[p] = '0;
        end
        for (int a = 0; a < 64; a++) begin
            logic [31:0] d;
            d = $urandom;
            ref_mem[a] = d;
            preload(a, d);
        end
        m_owner = -1;
        m_kind  = 0;
        m_wait  = 0;
        m_rd    = '0;
        vprev   = '0;

        for (int c = 0; c < 800; c++) begin
            cyc = 1000 + c;
            rst_in = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < 3; p++) begin
                if (vprev[p]) begin
                    if ($urandom_range(0, 1) == 1) new_req(p);
                    else rq[p] = 1'b0;
                end else if (!rq[p] &&
                             $urandom_range(0, 2) == 0) begin
                    new_req(p);
                end
            end
            drive_rand();
            @(negedge clk_in);
            model_eval();
            @(posedge clk_in);
            model_commit();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
